// File: rtl/neuron_core_pkg.sv
// Shared constants and types for the neuron core sequencer.
// Holds the default neuron count, potential width, index widths and FSM states.
// No logic here; imported by the sequencer and its bench.
package neuron_core_pkg;

    localparam int NUM_NEURONS = 256;  // neurons swept per packet (power of two, <= 256)
    localparam int PW          = 8;    // signed membrane potential width
    localparam int IDX_W       = 8;    // axon and neuron index width
    localparam int CNT_W       = 9;    // spike counter width (0..256)

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/neuron_core_sequencer.sv
// Sequences one spike packet over every neuron: read SRAM, run the datapath, write back, emit spikes.
// Latency: 3*NUM_NEURONS + EMIT cycles + 1 from packet acceptance to the done_o pulse.
// Backpressure: pkt_ready_o only in IDLE; spike events stall in EMIT until spk_ready_i.
//
// Ports: clk_i/rst_ni (async active-low); pkt_* packet handshake with axon/first/last;
// mem_* neuron SRAM strobes, address, axon, write data and read-back (one cycle read latency);
// nb_* combinational neuron datapath; spk_* spike event handshake; busy_o, done_o, spike_cnt_o status.
module neuron_core_sequencer #(
    parameter int NUM_NEURONS = neuron_core_pkg::NUM_NEURONS,
    parameter int PW          = neuron_core_pkg::PW
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 pkt_valid_i,
    output logic                                 pkt_ready_o,
    input  logic [neuron_core_pkg::IDX_W-1:0]    pkt_axon_i,
    input  logic                                 pkt_first_i,
    input  logic                                 pkt_last_i,
    output logic                                 mem_rd_o,
    output logic                                 mem_wr_o,
    output logic [neuron_core_pkg::IDX_W-1:0]    mem_addr_o,
    output logic [neuron_core_pkg::IDX_W-1:0]    mem_axon_o,
    output logic signed [PW-1:0]                 mem_wdata_o,
    input  logic                                 mem_conn_i,
    input  logic signed [PW-1:0]                 mem_pot_i,
    output logic                                 nb_en_o,
    output logic                                 nb_conn_o,
    output logic                                 nb_last_o,
    output logic signed [PW-1:0]                 nb_pot_o,
    input  logic signed [PW-1:0]                 nb_pot_i,
    input  logic                                 nb_spike_i,
    output logic                                 spk_valid_o,
    input  logic                                 spk_ready_i,
    output logic [neuron_core_pkg::IDX_W-1:0]    spk_id_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [neuron_core_pkg::CNT_W-1:0]    spike_cnt_o
);

    import neuron_core_pkg::*;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       n_q;
    logic [IDX_W-1:0]       axon_q;
    logic                   first_q, last_q, conn_q, spike_q;
    logic signed [PW-1:0]   pot_q;
    logic [CNT_W-1:0]       spike_cnt_q;
    logic                   live_q;     // low during reset and until the first edge after release
    logic                   accept, advance, n_last;

    assign n_last = (n_q == IDX_W'(NUM_NEURONS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pkt_ready_o = 1'b0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        nb_en_o     = 1'b0;
        spk_valid_o = 1'b0;
        done_o      = 1'b0;
        accept      = 1'b0;
        advance     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pkt_ready_o = live_q;
                if (pkt_valid_i && live_q) begin
                    accept  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd_o = 1'b1;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                nb_en_o = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Untouched neurons of a middle packet keep their stored value: skip the write.
                mem_wr_o = conn_q | first_q | last_q;
                if (last_q && spike_q) state_d = ST_EMIT;
                else                   advance = 1'b1;
            end
            ST_EMIT: begin
                spk_valid_o = 1'b1;
                advance     = spk_ready_i;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (advance) state_d = n_last ? ST_DONE : ST_READ;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q      <= 1'b0;
            n_q         <= '0;
            axon_q      <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            conn_q      <= 1'b0;
            spike_q     <= 1'b0;
            pot_q       <= '0;
            spike_cnt_q <= '0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                axon_q  <= pkt_axon_i;
                first_q <= pkt_first_i;
                last_q  <= pkt_last_i;
                n_q     <= '0;
                if (pkt_last_i) spike_cnt_q <= '0;
            end
            if (nb_en_o) begin
                pot_q   <= nb_pot_i;
                spike_q <= nb_spike_i;
                conn_q  <= mem_conn_i;
            end
            // The final neuron goes to DONE without incrementing, so n never wraps.
            if (advance && !n_last) n_q <= n_q + 1'b1;
            if (spk_valid_o && spk_ready_i) spike_cnt_q <= spike_cnt_q + 1'b1;
        end
    end

    assign mem_addr_o  = n_q;
    assign mem_axon_o  = axon_q;
    assign mem_wdata_o = pot_q;
    assign nb_conn_o   = mem_conn_i;
    assign nb_last_o   = last_q;
    // A first packet restarts every neuron from rest regardless of what the SRAM holds.
    assign nb_pot_o    = first_q ? '0 : mem_pot_i;
    assign spk_id_o    = n_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign spike_cnt_o = spike_cnt_q;

endmodule
